// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared constants, types and state enum for the pong ball engine
package pong_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_SCREEN_W     = 640;
    localparam int DEF_SCREEN_H     = 480;
    localparam int DEF_BALL_SIZE    = 8;
    localparam int DEF_PADDLE_W     = 8;
    localparam int DEF_PADDLE_H     = 64;
    localparam int DEF_PADDLE_LX    = 16;
    localparam int DEF_PADDLE_RX    = 616;
    localparam int DEF_SPEED        = 2;
    localparam int DEF_SERVE_FRAMES = 60;

    typedef logic        [COORD_W-1:0] coord_t;
    typedef logic signed [COORD_W:0]   scoord_t;

    typedef enum logic {
        SERVE = 1'b0,
        MOVE  = 1'b1
    } ball_state_e;

    // Top-left coordinate that centres an object of 'size' in a span of 'extent'.
    function automatic coord_t centre(input int extent, input int size);
        return coord_t'((extent - size) / 2);
    endfunction

endpackage

// File: rtl/pong_ball_if.sv
// rtl/pong_ball_if.sv - frame/paddle inputs and ball/score outputs of the ball engine
interface pong_ball_if
    import pong_pkg::*;
;
    logic   frame_tick;
    logic   game_enable;
    coord_t paddleL_y;
    coord_t paddleR_y;
    coord_t ball_x;
    coord_t ball_y;
    logic   serving;
    logic   left_point;
    logic   right_point;

    // Game logic side: drives ticks and paddles, observes the ball.
    modport master (
        output frame_tick, game_enable, paddleL_y, paddleR_y,
        input  ball_x, ball_y, serving, left_point, right_point
    );

    // Ball engine side.
    modport slave (
        input  frame_tick, game_enable, paddleL_y, paddleR_y,
        output ball_x, ball_y, serving, left_point, right_point
    );

endinterface

// File: rtl/pong_ball_next.sv
// rtl/pong_ball_next.sv - combinational next-position, bounce and miss evaluation
module pong_ball_next
    import pong_pkg::*;
#(
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int BALL_SIZE = DEF_BALL_SIZE,
    parameter int PADDLE_W  = DEF_PADDLE_W,
    parameter int PADDLE_H  = DEF_PADDLE_H,
    parameter int PADDLE_LX = DEF_PADDLE_LX,
    parameter int PADDLE_RX = DEF_PADDLE_RX,
    parameter int SPEED     = DEF_SPEED
) (
    input  coord_t x_i,
    input  coord_t y_i,
    input  logic   dx_i,          // 1 = moving right
    input  logic   dy_i,          // 1 = moving down
    input  coord_t paddle_l_y_i,
    input  coord_t paddle_r_y_i,
    output coord_t x_o,
    output coord_t y_o,
    output logic   dx_o,
    output logic   dy_o,
    output logic   miss_left_o,   // ball left the field on the left side
    output logic   miss_right_o   // ball left the field on the right side
);

    localparam scoord_t STEP   = scoord_t'(SPEED);
    localparam scoord_t L_FACE = scoord_t'(PADDLE_LX + PADDLE_W);
    localparam scoord_t R_FACE = scoord_t'(PADDLE_RX - BALL_SIZE);
    localparam scoord_t X_MAX  = scoord_t'(SCREEN_W - BALL_SIZE);
    localparam scoord_t Y_MAX  = scoord_t'(SCREEN_H - BALL_SIZE);
    localparam scoord_t ZERO   = scoord_t'(0);

    scoord_t xs;
    scoord_t ys;
    scoord_t nx;
    scoord_t ny;

    // Unsigned one-bit-wider copies so that y+size and paddle+height cannot wrap.
    logic [COORD_W:0] y_top;
    logic [COORD_W:0] y_bot;
    logic [COORD_W:0] pl_top;
    logic [COORD_W:0] pl_bot;
    logic [COORD_W:0] pr_top;
    logic [COORD_W:0] pr_bot;

    logic overlap_l;
    logic overlap_r;
    logic hit_l;
    logic hit_r;

    assign xs = scoord_t'({1'b0, x_i});
    assign ys = scoord_t'({1'b0, y_i});
    assign nx = dx_i ? (xs + STEP) : (xs - STEP);
    assign ny = dy_i ? (ys + STEP) : (ys - STEP);

    assign y_top  = {1'b0, y_i};
    assign y_bot  = y_top + (COORD_W+1)'(BALL_SIZE);
    assign pl_top = {1'b0, paddle_l_y_i};
    assign pl_bot = pl_top + (COORD_W+1)'(PADDLE_H);
    assign pr_top = {1'b0, paddle_r_y_i};
    assign pr_bot = pr_top + (COORD_W+1)'(PADDLE_H);

    // Overlap is judged on the current row, before any wall correction.
    assign overlap_l = (y_bot > pl_top) && (y_top < pl_bot);
    assign overlap_r = (y_bot > pr_top) && (y_top < pr_bot);

    // A hit needs the ball to cross the paddle face during this step.
    assign hit_l = !dx_i && (xs >= L_FACE) && (nx < L_FACE) && overlap_l;
    assign hit_r =  dx_i && (xs <= R_FACE) && (nx > R_FACE) && overlap_r;

    // Horizontal: paddle hits take priority over leaving the field.
    always_comb begin
        x_o          = nx[COORD_W-1:0];
        dx_o         = dx_i;
        miss_left_o  = 1'b0;
        miss_right_o = 1'b0;
        if (hit_l) begin
            x_o  = L_FACE[COORD_W-1:0];
            dx_o = 1'b1;
        end else if (hit_r) begin
            x_o  = R_FACE[COORD_W-1:0];
            dx_o = 1'b0;
        end else if (nx <= ZERO) begin
            miss_left_o = 1'b1;
        end else if (nx >= X_MAX) begin
            miss_right_o = 1'b1;
        end
    end

    // Vertical: clamp to the top/bottom walls and reflect.
    always_comb begin
        y_o  = ny[COORD_W-1:0];
        dy_o = dy_i;
        if (ny <= ZERO) begin
            y_o  = '0;
            dy_o = 1'b1;
        end else if (ny >= Y_MAX) begin
            y_o  = Y_MAX[COORD_W-1:0];
            dy_o = 1'b0;
        end
    end

endmodule

// File: rtl/pong_ball.sv
// rtl/pong_ball.sv - per-frame ball motion engine with serve hold and point pulses
module pong_ball
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_LX    = DEF_PADDLE_LX,
    parameter int PADDLE_RX    = DEF_PADDLE_RX,
    parameter int SPEED        = DEF_SPEED,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
    input  logic        clock,
    input  logic        reset,
    pong_ball_if.slave  bus
);

    localparam int            CNT_W  = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam coord_t        CX     = centre(SCREEN_W, BALL_SIZE);
    localparam coord_t        CY     = centre(SCREEN_H, BALL_SIZE);

    ball_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    coord_t           x_q;
    coord_t           y_q;
    logic             dx_q;
    logic             dy_q;
    logic             serving_q;
    logic             left_point_q;
    logic             right_point_q;

    coord_t x_d;
    coord_t y_d;
    logic   dx_d;
    logic   dy_d;
    logic   miss_left;
    logic   miss_right;

    pong_ball_next #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .BALL_SIZE (BALL_SIZE),
        .PADDLE_W  (PADDLE_W),
        .PADDLE_H  (PADDLE_H),
        .PADDLE_LX (PADDLE_LX),
        .PADDLE_RX (PADDLE_RX),
        .SPEED     (SPEED)
    ) u_next (
        .x_i          (x_q),
        .y_i          (y_q),
        .dx_i         (dx_q),
        .dy_i         (dy_q),
        .paddle_l_y_i (bus.paddleL_y),
        .paddle_r_y_i (bus.paddleR_y),
        .x_o          (x_d),
        .y_o          (y_d),
        .dx_o         (dx_d),
        .dy_o         (dy_d),
        .miss_left_o  (miss_left),
        .miss_right_o (miss_right)
    );

    // Serve/move FSM: every state change happens on a frame tick; point pulses self-clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= SERVE;
            cnt_q         <= '0;
            x_q           <= CX;
            y_q           <= CY;
            dx_q          <= 1'b1;
            dy_q          <= 1'b1;
            serving_q     <= 1'b1;
            left_point_q  <= 1'b0;
            right_point_q <= 1'b0;
        end else begin
            left_point_q  <= 1'b0;
            right_point_q <= 1'b0;
            if (bus.frame_tick) begin
                case (state_q)
                    SERVE: begin
                        x_q <= CX;
                        y_q <= CY;
                        if (!bus.game_enable) begin
                            cnt_q <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            // Launch tick: the ball leaves centre on the following tick.
                            state_q   <= MOVE;
                            serving_q <= 1'b0;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    MOVE: begin
                        if (!bus.game_enable || miss_left || miss_right) begin
                            state_q   <= SERVE;
                            serving_q <= 1'b1;
                            cnt_q     <= '0;
                            x_q       <= CX;
                            y_q       <= CY;
                            // A miss serves toward the side that conceded; a pause scores nothing.
                            if (bus.game_enable && miss_left) begin
                                right_point_q <= 1'b1;
                                dx_q          <= 1'b0;
                            end else if (bus.game_enable && miss_right) begin
                                left_point_q <= 1'b1;
                                dx_q         <= 1'b1;
                            end
                        end else begin
                            x_q  <= x_d;
                            y_q  <= y_d;
                            dx_q <= dx_d;
                            dy_q <= dy_d;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.ball_x      = x_q;
    assign bus.ball_y      = y_q;
    assign bus.serving     = serving_q;
    assign bus.left_point  = left_point_q;
    assign bus.right_point = right_point_q;

endmodule

// File: tb/tb_pong_ball.sv
// tb/tb_pong_ball.sv - self-checking bench for pong_ball and its next-position evaluator
module tb_pong_ball;
    import pong_pkg::*;

    localparam int CXI   = (DEF_SCREEN_W - DEF_BALL_SIZE) / 2;
    localparam int CYI   = (DEF_SCREEN_H - DEF_BALL_SIZE) / 2;
    localparam int LFACE = DEF_PADDLE_LX + DEF_PADDLE_W;
    localparam int RFACE = DEF_PADDLE_RX - DEF_BALL_SIZE;
    localparam int XMAX  = DEF_SCREEN_W - DEF_BALL_SIZE;
    localparam int YMAX  = DEF_SCREEN_H - DEF_BALL_SIZE;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pong_ball_if bus ();

    pong_ball dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    coord_t t_x, t_y, t_pl, t_pr, n_x, n_y;
    logic   t_dx, t_dy, n_dx, n_dy, n_ml, n_mr;

    pong_ball_next u_next (
        .x_i          (t_x),
        .y_i          (t_y),
        .dx_i         (t_dx),
        .dy_i         (t_dy),
        .paddle_l_y_i (t_pl),
        .paddle_r_y_i (t_pr),
        .x_o          (n_x),
        .y_o          (n_y),
        .dx_o         (n_dx),
        .dy_o         (n_dy),
        .miss_left_o  (n_ml),
        .miss_right_o (n_mr)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame-level reference: position in pixels, direction as +1/-1.
    int m_x, m_y, m_dx, m_dy, m_serve, m_cnt, m_lp, m_rp;

    task automatic model_reset();
        m_x = CXI; m_y = CYI; m_dx = 1; m_dy = 1;
        m_serve = 1; m_cnt = 0; m_lp = 0; m_rp = 0;
    endtask

    task automatic to_centre();
        m_serve = 1; m_cnt = 0; m_x = CXI; m_y = CYI;
    endtask

    task automatic model_step(input int en, input int pl, input int pr);
        int  nx, ny, ndy, dir;
        bit  hit;
        m_lp = 0;
        m_rp = 0;
        if (m_serve != 0) begin
            m_x = CXI;
            m_y = CYI;
            if (en == 0) m_cnt = 0;
            else if (m_cnt == DEF_SERVE_FRAMES - 1) begin m_serve = 0; m_cnt = 0; end
            else m_cnt++;
        end else if (en == 0) begin
            to_centre();
        end else begin
            dir = m_dx;
            nx  = m_x + m_dx * DEF_SPEED;
            ny  = m_y + m_dy * DEF_SPEED;
            hit = 0;
            if (dir < 0 && m_x >= LFACE && nx < LFACE &&
                m_y + DEF_BALL_SIZE > pl && m_y < pl + DEF_PADDLE_H) begin
                nx = LFACE; m_dx = 1; hit = 1;
            end
            if (dir > 0 && m_x <= RFACE && nx > RFACE &&
                m_y + DEF_BALL_SIZE > pr && m_y < pr + DEF_PADDLE_H) begin
                nx = RFACE; m_dx = -1; hit = 1;
            end
            ndy = m_dy;
            if (ny <= 0) begin ny = 0; ndy = 1; end
            else if (ny >= YMAX) begin ny = YMAX; ndy = -1; end
            if (!hit && nx <= 0) begin
                m_rp = 1; m_dx = -1; to_centre();
            end else if (!hit && nx >= XMAX) begin
                m_lp = 1; m_dx = 1; to_centre();
            end else begin
                m_x = nx; m_y = ny; m_dy = ndy;
            end
        end
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, "_x"},       int'(bus.ball_x),      m_x);
        check({tag, "_y"},       int'(bus.ball_y),      m_y);
        check({tag, "_serving"}, int'(bus.serving),     m_serve);
        check({tag, "_lpoint"},  int'(bus.left_point),  m_lp);
        check({tag, "_rpoint"},  int'(bus.right_point), m_rp);
    endtask

    // Tick edge, then compare on the following falling edge.
    task automatic tick_core(input int en, input string tag);
        @(negedge clock);
        bus.game_enable = en[0];
        bus.frame_tick  = 1'b1;
        model_step(en, int'(bus.paddleL_y), int'(bus.paddleR_y));
        @(negedge clock);
        bus.frame_tick = 1'b0;
        compare_outputs(tag);
    endtask

    task automatic tick(input int en, input string tag);
        tick_core(en, tag);
        @(negedge clock);
        check({tag, "_lpoint_drop"}, int'(bus.left_point),  0);
        check({tag, "_rpoint_drop"}, int'(bus.right_point), 0);
    endtask

    task automatic async_reset_check(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, "_x"},       int'(bus.ball_x),      CXI);
        check({tag, "_y"},       int'(bus.ball_y),      CYI);
        check({tag, "_serving"}, int'(bus.serving),     1);
        check({tag, "_lpoint"},  int'(bus.left_point),  0);
        check({tag, "_rpoint"},  int'(bus.right_point), 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        repeat (4) begin
            @(negedge clock);
            check({tag, "_nopulse"}, int'(bus.left_point | bus.right_point), 0);
        end
    endtask

    function automatic int clamp_paddle(input int p);
        if (p < 0) return 0;
        if (p > YMAX - DEF_PADDLE_H + DEF_BALL_SIZE) return YMAX - DEF_PADDLE_H + DEF_BALL_SIZE;
        return p;
    endfunction

    typedef struct {
        int x, y, dx, dy, pl, pr;
        int ex, ey, edx, edy, eml, emr;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int got;

        // Evaluator vectors: {x,y,dx,dy,pL,pR -> x,y,dx,dy,missL,missR}; dx/dy 1 = right/down.
        vecs[0]  = '{300,   1, 1, 0, 208, 208,  302,   0, 1, 1, 0, 0};
        vecs[1]  = '{300,   2, 1, 0, 208, 208,  302,   0, 1, 1, 0, 0};
        vecs[2]  = '{300, 471, 1, 1, 208, 208,  302, 472, 1, 0, 0, 0};
        vecs[3]  = '{300, 470, 1, 1, 208, 208,  302, 472, 1, 0, 0, 0};
        vecs[4]  = '{300, 468, 1, 1, 208, 208,  302, 470, 1, 1, 0, 0};
        vecs[5]  = '{607, 220, 1, 1, 208, 200,  608, 222, 0, 1, 0, 0};
        vecs[6]  = '{607, 192, 1, 1, 208, 200,  609, 194, 1, 1, 0, 0};
        vecs[7]  = '{607, 263, 1, 0, 208, 200,  608, 261, 0, 0, 0, 0};
        vecs[8]  = '{609, 220, 1, 1, 208, 200,  611, 222, 1, 1, 0, 0};
        vecs[9]  = '{ 25, 300, 0, 1, 280, 208,   24, 302, 1, 1, 0, 0};
        vecs[10] = '{ 24, 300, 0, 1, 280, 208,   24, 302, 1, 1, 0, 0};
        vecs[11] = '{  1, 300, 0, 1,   0, 208,    0, 302, 0, 1, 1, 0};
        vecs[12] = '{  2, 300, 0, 0,   0, 208,    0, 298, 0, 0, 1, 0};
        vecs[13] = '{631,  10, 1, 1, 208, 300,    0,  12, 1, 1, 0, 1};
        vecs[14] = '{630,  10, 1, 1, 208, 300,    0,  12, 1, 1, 0, 1};
        vecs[15] = '{628,  10, 1, 1, 208, 300,  630,  12, 1, 1, 0, 0};
        vecs[16] = '{607, 471, 1, 1, 208, 440,  608, 472, 0, 0, 0, 0};
        vecs[17] = '{  3, 300, 0, 1,   0, 208,    1, 302, 0, 1, 0, 0};

        bus.frame_tick  = 1'b0;
        bus.game_enable = 1'b1;
        bus.paddleL_y   = 10'd208;
        bus.paddleR_y   = 10'd208;

        for (int i = 0; i < 18; i++) begin
            t_x  = coord_t'(vecs[i].x);
            t_y  = coord_t'(vecs[i].y);
            t_dx = 1'(vecs[i].dx);
            t_dy = 1'(vecs[i].dy);
            t_pl = coord_t'(vecs[i].pl);
            t_pr = coord_t'(vecs[i].pr);
            #1;
            check($sformatf("vec%0d_missl", i), int'(n_ml), vecs[i].eml);
            check($sformatf("vec%0d_missr", i), int'(n_mr), vecs[i].emr);
            check($sformatf("vec%0d_y", i),     int'(n_y),  vecs[i].ey);
            check($sformatf("vec%0d_dy", i),    int'(n_dy), vecs[i].edy);
            if (vecs[i].eml == 0 && vecs[i].emr == 0) begin
                check($sformatf("vec%0d_x", i),  int'(n_x),  vecs[i].ex);
                check($sformatf("vec%0d_dx", i), int'(n_dx), vecs[i].edx);
            end
        end

        // Reset state, with frame ticks during reset that must be ignored.
        repeat (2) @(negedge clock);
        bus.frame_tick = 1'b1;
        @(negedge clock);
        bus.frame_tick = 1'b0;
        check("rst_x",       int'(bus.ball_x),      CXI);
        check("rst_y",       int'(bus.ball_y),      CYI);
        check("rst_serving", int'(bus.serving),     1);
        check("rst_lpoint",  int'(bus.left_point),  0);
        check("rst_rpoint",  int'(bus.right_point), 0);
        reset = 1'b0;
        model_reset();

        // Serve hold of 60 ticks, launch without moving, then first step.
        for (int k = 0; k < 59; k++) tick(1, "serve");
        check("serve_59_serving", int'(bus.serving), 1);
        tick(1, "launch");
        check("launch_serving", int'(bus.serving), 0);
        check("launch_x", int'(bus.ball_x), 316);
        tick(1, "first_move");
        check("first_move_x", int'(bus.ball_x), 318);
        check("first_move_y", int'(bus.ball_y), 238);

        // Paddles far from the ball's path: exits right, left player scores.
        got = 0;
        for (int k = 0; k < 300 && got == 0; k++) begin
            tick_core(1, "to_right");
            if (m_lp != 0) got = 1;
            @(negedge clock);
            check("to_right_drop", int'(bus.left_point | bus.right_point), 0);
        end
        check("left_point_seen", got, 1);
        check("after_lp_serving", int'(bus.serving), 1);
        check("after_lp_x", int'(bus.ball_x), 316);

        // Disabled game holds the serve indefinitely.
        for (int k = 0; k < 100; k++) tick(0, "hold");
        check("hold_serving", int'(bus.serving), 1);
        for (int k = 0; k < 59; k++) tick(1, "reserve");
        check("reserve_59_serving", int'(bus.serving), 1);
        tick(1, "relaunch");
        check("relaunch_serving", int'(bus.serving), 0);

        // Right paddle tracks the ball, left paddle stays away: right player scores.
        got = 0;
        for (int k = 0; k < 600 && got == 0; k++) begin
            bus.paddleR_y = coord_t'(clamp_paddle(m_y - 20));
            bus.paddleL_y = (m_y < 200) ? 10'd400 : 10'd0;
            tick_core(1, "rally");
            if (m_rp != 0) got = 1;
            @(negedge clock);
            check("rally_drop", int'(bus.left_point | bus.right_point), 0);
        end
        check("right_point_seen", got, 1);
        check("after_rp_serving", int'(bus.serving), 1);
        check("after_rp_y", int'(bus.ball_y), 236);
        for (int k = 0; k < 60; k++) tick(1, "serve_left");
        tick(1, "move_left");
        check("move_left_x", int'(bus.ball_x), 314);

        // Asynchronous reset between ticks while moving.
        for (int k = 0; k < 5; k++) tick(1, "pre_rst");
        async_reset_check("rst_move");

        // Asynchronous reset with a point pulse in flight.
        for (int k = 0; k < 60; k++) tick(1, "serve3");
        got = 0;
        for (int k = 0; k < 300 && got == 0; k++) begin
            bus.paddleR_y = (m_y < 200) ? 10'd400 : 10'd0;
            bus.paddleL_y = (m_y < 200) ? 10'd400 : 10'd0;
            tick_core(1, "flight");
            if (m_lp != 0 || m_rp != 0) got = 1;
            else @(negedge clock);
        end
        check("flight_pulse_seen", got, 1);
        async_reset_check("rst_pulse");

        // Randomised play against the reference model.
        for (int k = 0; k < 1500; k++) begin
            int p;
            if ($urandom_range(0, 99) < 70) begin
                p = clamp_paddle(m_y - int'($urandom_range(0, 60)));
                bus.paddleR_y = coord_t'(p);
                p = clamp_paddle(m_y - int'($urandom_range(0, 60)));
                bus.paddleL_y = coord_t'(p);
            end else begin
                bus.paddleR_y = coord_t'($urandom_range(0, 416));
                bus.paddleL_y = coord_t'($urandom_range(0, 416));
            end
            tick(($urandom_range(0, 99) < 97) ? 1 : 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pong_ball.md
# pong_ball

Ball-motion engine for the Pong datapath, directly upstream of the data-memory MMIO score block. It advances the ball once per video frame, bounces it off the top/bottom walls and both paddles, and raises a one-cycle point pulse when the ball leaves the field. The pulses drive the memory block's `left_point`/`right_point` inputs. `ball_x`/`ball_y` feed the VGA renderer.

## Interface
Parameters:
- `SCREEN_W`, 640, field width in pixels
- `SCREEN_H`, 480, field height in pixels
- `BALL_SIZE`, 8, square ball edge length
- `PADDLE_W`, 8, paddle width
- `PADDLE_H`, 64, paddle height
- `PADDLE_LX`, 16, left paddle x (left edge)
- `PADDLE_RX`, 616, right paddle x (left edge)
- `SPEED`, 2, pixels per frame on each axis
- `SERVE_FRAMES`, 60, frames held at centre before launch

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `frame_tick`  in  1  one-cycle pulse per frame (vblank start)
- `game_enable`  in  1  0 = hold ball in SERVE
- `paddleL_y`  in  10  left paddle top y
- `paddleR_y`  in  10  right paddle top y
- `ball_x`  out  10  ball top-left x
- `ball_y`  out  10  ball top-left y
- `serving`  out  1  high while in SERVE
- `left_point`  out  1  one-cycle pulse: left player scored (ball exited right)
- `right_point`  out  1  one-cycle pulse: right player scored (ball exited left)

## Operation
- Centre: CX = (SCREEN_W−BALL_SIZE)/2 = 316, CY = (SCREEN_H−BALL_SIZE)/2 = 236.
- Reset values: ball = (CX,CY), dx = +1 (right), dy = +1 (down), state SERVE, serve counter 0, serving = 1, both point pulses 0.
- All state changes occur only on edges where `frame_tick`=1.
- State SERVE:
  - `game_enable`=0: counter cleared, ball held at centre.
  - Otherwise the counter increments on each tick.
  - On the tick where counter = SERVE_FRAMES−1: go to MOVE, clear the counter. The ball does not move on this tick.
- State MOVE: nx = x + dx·SPEED and ny = y + dy·SPEED, computed as 11-bit signed.
- Walls:
  - ny ≤ 0: y=0, dy=+1.
  - ny ≥ SCREEN_H−BALL_SIZE: clamp to that value, dy=−1.
- Left paddle (dx=−1):
  - Condition: x ≥ PADDLE_LX+PADDLE_W, nx < PADDLE_LX+PADDLE_W, and vertical overlap (y+BALL_SIZE > paddleL_y and y < paddleL_y+PADDLE_H).
  - Action: x = PADDLE_LX+PADDLE_W, dx=+1.
- Right paddle (dx=+1): mirror of the left case, face at PADDLE_RX−BALL_SIZE.
  - Action: x = PADDLE_RX−BALL_SIZE, dx=−1.
- Overlap uses the current y, before the wall update.
- A wall bounce and a paddle bounce on the same tick are both applied.
- Miss left (nx ≤ 0, no paddle hit):
  - right_point pulse; ball to centre; state SERVE; dx=−1 (serve toward the conceding side); dy unchanged.
- Miss right (nx ≥ SCREEN_W−BALL_SIZE, no paddle hit):
  - left_point pulse; ball to centre; state SERVE; dx=+1.
- A paddle hit has priority over a miss on the same tick.
- `game_enable` dropping in MOVE: the ball finishes nothing. On the next tick it returns to centre in SERVE with no point pulse.
- Paddle inputs are sampled only on tick edges and must be stable around `frame_tick`.

## Timing
- Latency: outputs update on the clock edge that samples `frame_tick`, and are valid the following cycle.
- Point pulses are registered, high for exactly one cycle after that edge. They are never high in consecutive cycles and never both high.
- `serving` changes on the same edge as the state.
- A `frame_tick` during reset is ignored.
- Reset asserted mid-MOVE: outputs return to reset values immediately (asynchronously). A pulse in flight is cancelled.
- Reset deasserted: first counted tick is the first `frame_tick` after release.

## Structure
- Shared package `pong_pkg` holds:
  - screen, ball and paddle constants
  - the state enum {SERVE, MOVE}
  - the coordinate width (10)
- Sub-module `pong_ball_next`: purely combinational next-position, bounce and miss evaluation from (x, y, dx, dy, paddle y's). The top level owns the FSM, serve counter and output registers.

## Test plan
- Reset, enable=1, paddles at 208 → ball (316,236), serving=1. After 60 ticks: serving=0, ball still (316,236). Next tick: ball (318,238).
- Ball at (300,1), dy=−1 → tick → y=0, dy=+1. Next tick → y=2.
- paddleR_y=200, ball (607,220), dx=+1 → tick → x=608, dx=−1, no pulse.
- paddleL_y=0, ball (1,300), dx=−1 → tick → right_point high exactly 1 cycle, ball (316,236), serving=1. After serve, first move gives x=314.
- Ball (631,10), paddleR_y=300, dx=+1 → left_point pulse. game_enable=0 for 100 ticks → no launch. Enable → launch after 60 more ticks.
- Reset asserted mid-MOVE between ticks → ball (316,236), serving=1 the same cycle, no pulse on release.
